mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM states,
// requester identifiers and the memory word width.
package mem_arb_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-cycle memory between instruction fetch
// and data access; data has priority unless fetch has been starved too long.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_addr,
    output logic              if_done,
    output logic [WORD_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    input  logic              d_we,
    output logic              d_done,
    output logic [WORD_W-1:0] d_rdata,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_write_data,
    output logic              mem_MemWrite,
    input  logic [WORD_W-1:0] mem_read_data
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    state_e            state_q, state_d;
    req_id_e           grant_q;
    logic              we_q;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [WORD_W-1:0] mem_addr_q, mem_wdata_q;
    logic [WORD_W-1:0] if_rdata_q, d_rdata_q;
    logic              take_if, take_d;

    // Arbitration: data wins unless fetch has waited STARVE_LIMIT data grants.
    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        take_if  = if_req && (!d_req || (starve_q == LIMIT_C));
        take_d   = d_req && !take_if;
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (take_if) begin
                starve_d = '0;
            end else if (take_d && if_req && (starve_q != LIMIT_C)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments only.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (if_req || d_req) state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_MemWrite = 1'b0;
        if_done      = 1'b0;
        d_done       = 1'b0;
        case (state_q)
            ACCESS:  mem_MemWrite = we_q;
            DONE: begin
                if_done = (grant_q == REQ_IF);
                d_done  = (grant_q == REQ_D);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q     <= REQ_IF;
            we_q        <= 1'b0;
            starve_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            starve_q <= starve_d;
            if (state_q == IDLE) begin
                if (take_if) begin
                    grant_q    <= REQ_IF;
                    mem_addr_q <= if_addr;
                    we_q       <= 1'b0;
                end else if (take_d) begin
                    grant_q     <= REQ_D;
                    mem_addr_q  <= d_addr;
                    mem_wdata_q <= d_wdata;
                    we_q        <= d_we;
                end
            end
            // A store leaves the last loaded word in d_rdata untouched.
            if (state_q == ACCESS) begin
                if (grant_q == REQ_IF) begin
                    if_rdata_q <= mem_read_data;
                end else if (!we_q) begin
                    d_rdata_q <= mem_read_data;
                end
            end
        end
    end

    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
    assign if_rdata       = if_rdata_q;
    assign d_rdata        = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requesters push expected completions,
// a negedge monitor pops and compares them when a done pulse appears.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_done, d_done, mem_MemWrite;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_write_data, mem_read_data;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_rdata       (if_rdata),
        .d_req          (d_req),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_we           (d_we),
        .d_done         (d_done),
        .d_rdata        (d_rdata),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_MemWrite   (mem_MemWrite),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        req_id_e     id;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    req_id_e     got_id;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          if_done_cyc = 0;
    int          d_done_cyc = 0;
    logic [31:0] wr_addr_last, wr_data_last;
    logic [31:0] mem [0:255];

    assign mem_read_data = mem[mem_addr[7:0]];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0]   = 32'h0000_0008;
        mem[128] = 32'h8c03_0000;
        forever begin
            @(posedge clk);
            if (mem_MemWrite) mem[mem_addr[7:0]] <= mem_write_data;
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push(input req_id_e id, input logic [31:0] rdata);
        exp_t e;
        e.id    = id;
        e.rdata = rdata;
        sb.push_back(e);
    endtask

    // Monitor: write tracking and scoreboard comparison on done pulses.
    initial forever begin
        @(negedge clk);
        if (mem_MemWrite) begin
            wr_cnt++;
            wr_addr_last = mem_addr;
            wr_data_last = mem_write_data;
        end
        if (if_done && d_done) check("both_done", 32'(if_done), 32'(!d_done));
        if (if_done || d_done) begin
            if (if_done) if_done_cyc = cyc;
            if (d_done)  d_done_cyc  = cyc;
            if (sb.size() == 0) begin
                check("spurious_done", {30'd0, if_done, d_done}, 32'd0);
            end else begin
                mon_e  = sb.pop_front();
                got_id = d_done ? REQ_D : REQ_IF;
                check("done_id", 32'(got_id), 32'(mon_e.id));
                check(d_done ? "d_rdata" : "if_rdata", d_done ? d_rdata : if_rdata, mon_e.rdata);
            end
        end
    end

    task automatic do_fetch(input logic [31:0] a, output int lat);
        if_addr = a;
        if_req  = 1'b1;
        lat     = 0;
        while (1'b1) begin
            @(negedge clk);
            lat++;
            if (if_done) break;
            if (lat >= 40) begin
                check("if_timeout", 32'(if_done), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    task automatic do_data(input logic [31:0] a, input logic [31:0] wd, input logic we,
                           output int lat);
        d_addr  = a;
        d_wdata = wd;
        d_we    = we;
        d_req   = 1'b1;
        lat     = 0;
        while (1'b1) begin
            @(negedge clk);
            lat++;
            if (d_done) break;
            if (lat >= 40) begin
                check("d_timeout", 32'(d_done), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_mem_addr"}, mem_addr, 32'd0);
        check({pfx, "_mem_wdata"}, mem_write_data, 32'd0);
        check({pfx, "_memwrite"}, 32'(mem_MemWrite), 32'd0);
        check({pfx, "_if_done"}, 32'(if_done), 32'd0);
        check({pfx, "_d_done"}, 32'(d_done), 32'd0);
        check({pfx, "_if_rdata"}, if_rdata, 32'd0);
        check({pfx, "_d_rdata"}, d_rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        int lat, lat_f, lat_d, n;
        reset   = 1'b1;
        if_req  = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        if_addr = '0;
        d_addr  = '0;
        d_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fetch of word 128.
        wr_cnt = 0;
        push(REQ_IF, 32'h8c03_0000);
        do_fetch(32'd128, lat);
        check("fetch_lat", 32'(lat), 32'd3);
        check("fetch_no_write", 32'(wr_cnt), 32'd0);

        // Store 0xF to 6, load it back, then a store must not disturb d_rdata.
        wr_cnt = 0;
        push(REQ_D, 32'd0);
        do_data(32'd6, 32'h0000_000F, 1'b1, lat);
        check("store_lat", 32'(lat), 32'd3);
        check("store_wr_cnt", 32'(wr_cnt), 32'd1);
        check("store_wr_addr", wr_addr_last, 32'd6);
        check("store_wr_data", wr_data_last, 32'h0000_000F);
        push(REQ_D, 32'h0000_000F);
        do_data(32'd6, 32'd0, 1'b0, lat);
        wr_cnt = 0;
        push(REQ_D, 32'h0000_000F);
        do_data(32'd7, 32'h0000_00AB, 1'b1, lat);
        check("store2_wr_cnt", 32'(wr_cnt), 32'd1);
        push(REQ_D, 32'h0000_00AB);
        do_data(32'd7, 32'd0, 1'b0, lat);

        // Simultaneous requests: data first, fetch one access later.
        push(REQ_D, 32'd8);
        push(REQ_IF, 32'h8c03_0000);
        fork
            do_data(32'd0, 32'd0, 1'b0, lat_d);
            do_fetch(32'd128, lat_f);
        join
        check("sim_d_lat", 32'(lat_d), 32'd3);
        check("sim_if_lat", 32'(lat_f), 32'd6);
        check("sim_gap", 32'(if_done_cyc - d_done_cyc), 32'd3);

        // Starvation: four data grants, then fetch, then data resumes.
        for (int k = 0; k < 4; k++) push(REQ_D, 32'h1000_0010 + 32'(k));
        push(REQ_IF, 32'h8c03_0000);
        push(REQ_D, 32'h1000_0014);
        push(REQ_D, 32'h1000_0015);
        fork
            do_fetch(32'd128, lat_f);
            begin
                for (int k = 0; k < 6; k++) do_data(32'd16 + 32'(k), 32'd0, 1'b0, lat_d);
            end
        join
        check("starve_if_lat", 32'(lat_f), 32'd15);

        // Reset while a store is in ACCESS aborts it.
        d_addr  = 32'd9;
        d_wdata = 32'h0000_0055;
        d_we    = 1'b1;
        d_req   = 1'b1;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (mem_MemWrite) break;
        end
        check("rst_in_access", 32'(mem_MemWrite), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        push(REQ_IF, 32'h8c03_0000);
        do_fetch(32'd128, lat);
        check("post_rst_lat", 32'(lat), 32'd3);
        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
